// File: rtl/adder26_mp_arbiter_pkg.sv
// Shared definitions for the two-requester multi-precision adder sequencer.
package adder26_mp_arbiter_pkg;

  localparam int unsigned ADD_W = 26;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/Full_adder_26bits.sv
// 26-bit ripple-carry adder; sum[26] is the carry-out.
module Full_adder_26bits (
  output logic [26:0] sum,
  input  logic [25:0] a,
  input  logic [25:0] b,
  input  logic        c_in
);

  logic w_c;

  always_comb begin
    sum = '0;
    w_c = c_in;
    for (int i = 0; i < 26; i++) begin
      sum[i] = a[i] ^ b[i] ^ w_c;
      w_c    = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
    end
    sum[26] = w_c;
  end

endmodule

// File: rtl/adder26_mp_arbiter.sv
// Round-robin arbiter sharing one 26-bit adder between two requesters;
// adds WORDS-word operands serially, one word per clock.
module adder26_mp_arbiter
  import adder26_mp_arbiter_pkg::*;
#(
  parameter int unsigned WORDS = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [WORDS*ADD_W-1:0]   req0_a,
  input  logic [WORDS*ADD_W-1:0]   req0_b,
  input  logic                     req0_cin,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [WORDS*ADD_W-1:0]   req1_a,
  input  logic [WORDS*ADD_W-1:0]   req1_b,
  input  logic                     req1_cin,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WORDS*ADD_W:0]     res_sum,
  output logic                     res_id
);

  localparam int unsigned OPW = WORDS * ADD_W;
  localparam int unsigned KW  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  state_e           r_state, w_state_next;
  logic [OPW-1:0]   r_a, r_b;
  logic             r_carry;
  logic [KW-1:0]    r_k;
  logic [OPW:0]     r_sum;
  logic             r_id;
  logic             r_last;
  logic             w_grant;
  logic             w_idle;
  logic             w_accept;
  logic [ADD_W:0]   w_sum;

  // On a tie the requester that was not served last wins.
  always_comb begin
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last;
    end else begin
      w_grant = req1_valid ? ID_REQ1 : ID_REQ0;
    end
    w_idle     = rst_n && (r_state == StIdle);
    req0_ready = w_idle && req0_valid && (w_grant == ID_REQ0);
    req1_ready = w_idle && req1_valid && (w_grant == ID_REQ1);
    w_accept   = req0_ready || req1_ready;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StRun;
      StRun:   if (r_k == K_LAST) w_state_next = StDone;
      StDone:  if (res_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  Full_adder_26bits u_adder (
    .sum  (w_sum),
    .a    (r_a[ADD_W-1:0]),
    .b    (r_b[ADD_W-1:0]),
    .c_in (r_carry)
  );

  // Operands shift down one word per RUN cycle so the adder always sees word k at the bottom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_sum   <= '0;
      r_id    <= ID_REQ0;
      r_last  <= ID_REQ1;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_a     <= (w_grant == ID_REQ1) ? req1_a : req0_a;
            r_b     <= (w_grant == ID_REQ1) ? req1_b : req0_b;
            r_carry <= (w_grant == ID_REQ1) ? req1_cin : req0_cin;
            r_k     <= '0;
            r_id    <= w_grant;
            r_last  <= w_grant;
          end
        end
        StRun: begin
          r_sum[r_k*ADD_W +: ADD_W] <= w_sum[ADD_W-1:0];
          r_carry                   <= w_sum[ADD_W];
          r_a                       <= r_a >> ADD_W;
          r_b                       <= r_b >> ADD_W;
          if (r_k == K_LAST) begin
            r_sum[OPW] <= w_sum[ADD_W];
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign res_valid = (r_state == StDone);
  assign res_sum   = r_sum;
  assign res_id    = r_id;

endmodule
